// File: rtl/bcd_scan_if.sv
// Digit-scanner bus: frame load and blanking controls in, one scanned digit slot out.
interface bcd_scan_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                  load;
    logic [4*DIGITS-1:0]   digits_in;
    logic                  blank_lz;
    logic [3:0]            bcd;
    logic [DIGITS-1:0]     an;
    logic [IDX_W-1:0]      digit_idx;
    logic                  frame_done;

    modport master (
        output load, digits_in, blank_lz,
        input  bcd, an, digit_idx, frame_done
    );

    modport slave (
        input  load, digits_in, blank_lz,
        output bcd, an, digit_idx, frame_done
    );
endinterface

// File: rtl/bcd_digit_scanner.sv
// Multiplexed common-anode 7-segment scanner with a double-buffered BCD frame,
// leading-zero blanking and invalid-code blanking.
module bcd_digit_scanner #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic         clk,
    input  logic         rst,
    bcd_scan_if.slave    bus
);
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DIV_W  = $clog2(SCAN_DIV);
    localparam int unsigned DATA_W = 4 * DIGITS;

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   pending_q, pending_d;
    logic                pend_vld_q, pend_vld_d;
    logic [DATA_W-1:0]   display_q, display_d;
    logic                frame_done_q, frame_done_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [3:0]          bcd_q, bcd_d;

    logic                tick;
    logic                wrap;
    logic                zero_above;
    logic [DIGITS-1:0]   blanked;
    logic [3:0]          cur_code;
    logic                cur_blank;

    // Next-state and next-output decode; outputs are derived from the
    // post-edge state so an, bcd and digit_idx always move together.
    always_comb begin
        state_d      = ST_SCAN;
        div_d        = div_q;
        idx_d        = idx_q;
        pending_d    = pending_q;
        pend_vld_d   = pend_vld_q;
        display_d    = display_q;
        tick         = 1'b0;
        wrap         = 1'b0;
        zero_above   = 1'b1;
        blanked      = '0;
        cur_code     = 4'd0;
        cur_blank    = 1'b1;
        an_d         = '1;
        bcd_d        = 4'd0;

        // The prescaler only runs once scanning has started, so the first
        // lit slot gets its full SCAN_DIV cycles.
        if (state_q == ST_SCAN) begin
            tick  = (div_q == DIV_W'(SCAN_DIV - 1));
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    idx_d = '0;
                    wrap  = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end

        // Frame swap only on the boundary; a same-cycle load bypasses pending.
        if (wrap) begin
            if (bus.load) begin
                display_d = bus.digits_in;
            end else if (pend_vld_q) begin
                display_d = pending_q;
            end
            pend_vld_d = 1'b0;
        end else if (bus.load) begin
            pending_d  = bus.digits_in;
            pend_vld_d = 1'b1;
        end

        // Scan from the most significant digit down to find leading zeros.
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (display_d[4*k +: 4] == 4'd0);
            blanked[k] = (display_d[4*k +: 4] > 4'd9)
                       || (bus.blank_lz && (k != 0) && zero_above);
        end

        for (int k = 0; k < DIGITS; k++) begin
            if (IDX_W'(k) == idx_d) begin
                cur_code  = display_d[4*k +: 4];
                cur_blank = blanked[k];
            end
        end

        if ((state_d == ST_SCAN) && !cur_blank) begin
            bcd_d = cur_code;
            for (int k = 0; k < DIGITS; k++) begin
                if (IDX_W'(k) == idx_d) begin
                    an_d[k] = 1'b0;
                end
            end
        end

        frame_done_d = wrap;
    end

    // State register; reset wins over any simultaneous load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            idx_q        <= '0;
            pending_q    <= '0;
            pend_vld_q   <= 1'b0;
            display_q    <= '0;
            frame_done_q <= 1'b0;
            an_q         <= '1;
            bcd_q        <= 4'd0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            pend_vld_q   <= pend_vld_d;
            display_q    <= display_d;
            frame_done_q <= frame_done_d;
            an_q         <= an_d;
            bcd_q        <= bcd_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.bcd        = bcd_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Randomized self-checking bench for bcd_digit_scanner against a cycle-count
// based reference model.
module tb_bcd_digit_scanner;
    localparam int unsigned D = 4;
    localparam int unsigned S = 4;
    localparam int unsigned F = D * S;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_scan_if #(.DIGITS(D)) bus();

    bcd_digit_scanner #(.DIGITS(D), .SCAN_DIV(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: m_n counts non-reset edges since the last reset.
    int          m_n;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_pvld;
    bit          m_blz;

    function automatic int model_pos();
        return (m_n > 0) ? ((m_n - 1) / S) % D : 0;
    endfunction

    // Expected {an, bcd, digit_idx, frame_done} for the current model state.
    function automatic logic [10:0] model_out();
        logic [3:0] an;
        logic [3:0] b;
        logic [3:0] nib;
        bit         blank;
        bit         fd;
        int         pos;
        an  = 4'b1111;
        b   = 4'd0;
        fd  = 1'b0;
        pos = model_pos();
        if (m_n > 0) begin
            fd    = (m_n > 1) && (((m_n - 1) % F) == 0);
            nib   = 4'((m_disp >> (4 * pos)) & 16'hF);
            blank = (nib > 4'd9) || (m_blz && pos != 0 && (m_disp >> (4 * pos)) == 16'd0);
            if (!blank) begin
                an[pos] = 1'b0;
                b       = nib;
            end
        end
        return {an, b, 2'(pos), fd};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle.
    task automatic step(input bit r, input bit ld, input logic [15:0] d, input bit blz);
        rst           = r;
        bus.load      = ld;
        bus.digits_in = d;
        bus.blank_lz  = blz;
        @(posedge clk);
        if (r) begin
            m_n    = 0;
            m_disp = 16'd0;
            m_pend = 16'd0;
            m_pvld = 1'b0;
        end else begin
            m_n++;
            if ((m_n > 1) && (((m_n - 1) % F) == 0)) begin
                if (ld)          m_disp = d;
                else if (m_pvld) m_disp = m_pend;
                m_pvld = 1'b0;
            end else if (ld) begin
                m_pend = d;
                m_pvld = 1'b1;
            end
        end
        m_blz = blz;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 1'b1);
            tests++;
            if ({bus.an, bus.bcd, bus.digit_idx, bus.frame_done} !== 11'b1111_0000_00_0) begin
                fails++;
                $display("FAIL reset cyc %0d: got an=%b bcd=%h idx=%0d fd=%b, want an=1111 bcd=0 idx=0 fd=0",
                         i, bus.an, bus.bcd, bus.digit_idx, bus.frame_done);
            end
        end
    endtask

    task automatic test_idle_scan();
        int pulses = 0;
        for (int i = 0; i < 2 * F + 4; i++) begin
            step(1'b0, 1'b0, 16'd0, (i < F + 2));
            if (bus.frame_done === 1'b1) pulses++;
            tests++;
            if ({bus.an, bus.bcd, bus.digit_idx, bus.frame_done} !== model_out()) begin
                fails++;
                $display("FAIL idle_scan cyc %0d: got {an,bcd,idx,fd}=%b want %b",
                         i, {bus.an, bus.bcd, bus.digit_idx, bus.frame_done}, model_out());
            end
        end
        // 36 cycles from release cover boundaries at edges 17 and 33
        tests++;
        if (pulses != 2) begin
            fails++;
            $display("FAIL idle_frame_done_count: got %0d want 2", pulses);
        end
    endtask

    task automatic test_load_midframe();
        bit seen = 1'b0;
        for (int i = 0; i < F && ((m_n - 1) % F) != 6; i++) step(1'b0, 1'b0, 16'd0, 1'b0);
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        for (int i = 0; i < F + 12; i++) begin
            step(1'b0, 1'b0, 16'd0, 1'b0);
            tests++;
            if ({bus.an, bus.bcd, bus.digit_idx, bus.frame_done} !== model_out()) begin
                fails++;
                $display("FAIL load_midframe cyc %0d: got {an,bcd,idx,fd}=%b want %b",
                         i, {bus.an, bus.bcd, bus.digit_idx, bus.frame_done}, model_out());
            end
            if (!seen && ((m_n - 1) % F) == 0) begin
                seen = 1'b1;
                tests++;
                if (bus.frame_done !== 1'b1 || bus.bcd !== 4'd4 || bus.an !== 4'b1110) begin
                    fails++;
                    $display("FAIL first_digit_at_boundary: got fd=%b bcd=%h an=%b want fd=1 bcd=4 an=1110",
                             bus.frame_done, bus.bcd, bus.an);
                end
            end
        end
    endtask

    task automatic test_blanking(input logic [15:0] val, input string name);
        step(1'b0, 1'b1, val, 1'b1);
        for (int i = 0; i < 3 * F; i++) begin
            step(1'b0, 1'b0, 16'd0, (i < 2 * F));
            tests++;
            if ({bus.an, bus.bcd, bus.digit_idx, bus.frame_done} !== model_out()) begin
                fails++;
                $display("FAIL %s cyc %0d: got {an,bcd,idx,fd}=%b want %b",
                         name, i, {bus.an, bus.bcd, bus.digit_idx, bus.frame_done}, model_out());
            end
        end
    endtask

    task automatic test_lz_explicit();
        // display holds 16'h0050 here; slot 3 is blanked with blank_lz and shows 0 without
        for (int i = 0; i < F; i++) begin
            step(1'b0, 1'b0, 16'd0, 1'b1);
            if (model_pos() == 3) begin
                tests++;
                if (bus.an !== 4'b1111 || bus.bcd !== 4'd0) begin
                    fails++;
                    $display("FAIL lz_blank_pos3: got an=%b bcd=%h want an=1111 bcd=0", bus.an, bus.bcd);
                end
            end
        end
        for (int i = 0; i < F; i++) begin
            step(1'b0, 1'b0, 16'd0, 1'b0);
            if (model_pos() == 3) begin
                tests++;
                if (bus.an !== 4'b0111 || bus.bcd !== 4'd0) begin
                    fails++;
                    $display("FAIL lz_off_pos3: got an=%b bcd=%h want an=0111 bcd=0", bus.an, bus.bcd);
                end
            end
        end
    endtask

    task automatic test_invalid_explicit();
        // display holds 16'h12A4 here; slot 1 must be dark
        for (int i = 0; i < F; i++) begin
            step(1'b0, 1'b0, 16'd0, 1'b0);
            if (model_pos() == 1) begin
                tests++;
                if (bus.an !== 4'b1111 || bus.bcd !== 4'd0) begin
                    fails++;
                    $display("FAIL invalid_pos1: got an=%b bcd=%h want an=1111 bcd=0", bus.an, bus.bcd);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < F && ((m_n - 1) % F) != 2; i++) step(1'b0, 1'b0, 16'd0, 1'b0);
        step(1'b0, 1'b1, 16'h1111, 1'b0);
        step(1'b0, 1'b0, 16'd0, 1'b0);
        step(1'b0, 1'b1, 16'h2222, 1'b0);
        for (int i = 0; i < F && (m_n % F) != 0; i++) step(1'b0, 1'b0, 16'd0, 1'b0);
        step(1'b0, 1'b1, 16'h3333, 1'b0);
        tests++;
        if (bus.bcd !== 4'd3 || bus.frame_done !== 1'b1 || bus.an !== 4'b1110) begin
            fails++;
            $display("FAIL boundary_bypass: got bcd=%h fd=%b an=%b want bcd=3 fd=1 an=1110",
                     bus.bcd, bus.frame_done, bus.an);
        end
        // Run past the next boundary: a stale pending 2222 must not reappear.
        for (int i = 0; i < F + 4; i++) begin
            step(1'b0, 1'b0, 16'd0, 1'b0);
            tests++;
            if (bus.bcd !== 4'd3 || {bus.an, bus.bcd, bus.digit_idx, bus.frame_done} !== model_out()) begin
                fails++;
                $display("FAIL back_to_back cyc %0d: got {an,bcd,idx,fd}=%b want %b",
                         i, {bus.an, bus.bcd, bus.digit_idx, bus.frame_done}, model_out());
            end
        end
    endtask

    task automatic test_reset_midload();
        step(1'b0, 1'b0, 16'd0, 1'b0);
        step(1'b0, 1'b0, 16'd0, 1'b0);
        step(1'b1, 1'b1, 16'h5678, 1'b0);
        tests++;
        if (bus.an !== 4'b1111 || bus.bcd !== 4'd0 || bus.digit_idx !== 2'd0) begin
            fails++;
            $display("FAIL reset_midload: got an=%b bcd=%h idx=%0d want an=1111 bcd=0 idx=0",
                     bus.an, bus.bcd, bus.digit_idx);
        end
        for (int i = 0; i < F + 4; i++) begin
            step(1'b0, 1'b0, 16'd0, 1'b0);
            tests++;
            if ({bus.an, bus.bcd, bus.digit_idx, bus.frame_done} !== model_out()) begin
                fails++;
                $display("FAIL after_reset cyc %0d: got {an,bcd,idx,fd}=%b want %b",
                         i, {bus.an, bus.bcd, bus.digit_idx, bus.frame_done}, model_out());
            end
        end
        tests++;
        if (bus.bcd !== 4'd0) begin
            fails++;
            $display("FAIL lost_load: got bcd=%h want 0", bus.bcd);
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        bit          blz = 1'b1;
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 4; k++) begin
                d[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
            end
            if ($urandom_range(0, 40) == 0) blz = ~blz;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0), d, blz);
            tests++;
            if ({bus.an, bus.bcd, bus.digit_idx, bus.frame_done} !== model_out()) begin
                fails++;
                $display("FAIL random cyc %0d: got {an,bcd,idx,fd}=%b want %b",
                         i, {bus.an, bus.bcd, bus.digit_idx, bus.frame_done}, model_out());
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        bus.blank_lz  = 1'b1;
        m_n    = 0;
        m_disp = 16'd0;
        m_pend = 16'd0;
        m_pvld = 1'b0;
        m_blz  = 1'b1;

        test_reset();
        test_idle_scan();
        test_load_midframe();
        test_blanking(16'h0050, "lz_0050");
        test_lz_explicit();
        test_blanking(16'h12A4, "invalid_12A4");
        test_invalid_explicit();
        test_back_to_back();
        test_reset_midload();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bcd_digit_scanner.md
# bcd_digit_scanner

Time-multiplexed driver for a multi-digit common-anode 7-segment display. It holds a frame of BCD digits, cycles through the digit positions at a programmable rate, and presents one digit code per slot to the existing `segment7` decoder together with the matching active-low anode enable. Digit updates are double-buffered so a frame is never torn mid-scan. Optional leading-zero blanking and invalid-code blanking are included.

## Interface
Parameters:
- `DIGITS`, 4: number of digit positions (2..8).
- `SCAN_DIV`, 1000: clock cycles each digit stays lit (≥2).

Ports:
- `clk`  input  1  single system clock; all state changes on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `load`  input  1  one-cycle strobe: capture `digits_in` into the pending buffer.
- `digits_in`  input  4*DIGITS  BCD digits; `[3:0]` is digit 0 (rightmost, least significant).
- `blank_lz`  input  1  level: 1 enables leading-zero blanking.
- `bcd`  output  4  code of the currently scanned digit; drives `segment7.bcd`.
- `an`  output  DIGITS  active-low anode enables; at most one bit low.
- `digit_idx`  output  $clog2(DIGITS)  index of the currently scanned position.
- `frame_done`  output  1  one-cycle pulse at each frame boundary.

## Operation
- Registers: prescaler `div_cnt` (0..SCAN_DIV-1), `digit_idx` (0..DIGITS-1), `pending` buffer plus `pend_vld` flag, `display` buffer, `active` flag.
- Prescaler increments every cycle; at SCAN_DIV-1 it wraps to 0 and the `tick` condition is true for that cycle.
- On `tick`: `digit_idx` increments; from DIGITS-1 it wraps to 0 (frame boundary).
- `load`: `pending <= digits_in`, `pend_vld <= 1`. Several loads before a boundary: last one wins.
- Frame boundary with `pend_vld`=1 and no `load`: `display <= pending`, `pend_vld <= 0`.
- Frame boundary with `load`=1 in the same cycle: `display <= digits_in` directly (bypass), `pend_vld <= 0`.
- `display` never changes except at a frame boundary.
- Blanking of position k (derived from `display` and `digit_idx`):
  - Invalid code: `display[k]` > 9 -> blanked.
  - Leading zero: `blank_lz`=1, k ≠ 0, and `display[k..DIGITS-1]` are all 0 -> blanked. Digit 0 is never leading-zero blanked.
- `an`: all ones when `active`=0 or the current position is blanked; otherwise only bit `digit_idx` is low.
- `bcd`: `display[digit_idx]` when shown, 4'd0 when blanked or `active`=0.
- `frame_done`: high for exactly the cycle after the edge on which `digit_idx` wrapped to 0, coinciding with the first cycle the new `display` is visible.

## Timing
- Reset, i.e. any edge with `rst`=1:
  - Clears `div_cnt`, `digit_idx`, `pending`, `pend_vld`, `display`, `active`, and `frame_done`.
  - Outputs: `an` all ones, `bcd` 0, `digit_idx` 0, `frame_done` 0.
- Reset overrides everything, including a simultaneous `load`. Reset mid-frame discards pending data.
- First edge with `rst`=0: `active <= 1`. Digit 0 is lit from the next cycle with `display`=0, so the display shows "0", or "0000" when `blank_lz`=0.
- Each position is lit for exactly SCAN_DIV cycles. A frame lasts DIGITS*SCAN_DIV cycles, and `frame_done` has that period.
- `bcd`, `an`, and `digit_idx` change on the same edge; there is no cycle where `an` selects one position while `bcd` shows another.
- Load-to-display latency: up to one frame, with the update only at a boundary. With a `load` exactly on a boundary cycle, the value is visible the next cycle.
- `blank_lz` is sampled combinationally against `display`, so a change takes effect on the next cycle's outputs.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=4.
- Reset then idle 16 cycles -> `an` cycles 1110, 1111, 1111, 1111 (`blank_lz`=1) with `bcd`=0. With `blank_lz`=0: 1110, 1101, 1011, 0111, each held 4 cycles. `frame_done` pulses every 16 cycles.
- Load 16'h1234 mid-frame -> old digits persist until the boundary. Next frame shows `bcd` 4, 3, 2, 1 with `an` 1110, 1101, 1011, 0111. `frame_done` coincides with the first "4".
- Load 16'h0050, `blank_lz`=1 -> position 3 blanked (`an`=1111, `bcd`=0); positions 0..2 show 0, 5, 0. With `blank_lz`=0, position 3 shows 0.
- Load 16'h12A4 -> position 1 blanked, `bcd`=0 in that slot; the others show 4, 2, 1.
- Loads 16'h1111 then 16'h2222 in one frame, plus a `load` of 16'h3333 exactly on the boundary cycle -> next frame shows all 3s and `pend_vld`=0.
- Assert `rst` mid-frame during a `load` -> next cycle `an`=1111, `bcd`=0. After release, display restarts at digit 0 showing 0, and the loaded value is lost.
